// File: rtl/matrix_pe_param.sv
// Multi-lane signed dot-product engine: accumulates a uop-specified number of
// neuron x weight beats, then presents a saturated/ReLU'd result under backpressure.
module matrix_pe_param #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int RW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES*DW-1:0] nram_mpe_neuron,
  input  logic                nram_mpe_neuron_valid,
  output logic                nram_mpe_neuron_ready,
  input  logic [LANES*DW-1:0] wram_mpe_weight,
  input  logic                wram_mpe_weight_valid,
  output logic                wram_mpe_weight_ready,
  input  logic [7:0]          ib_ctl_uop,
  input  logic                ib_ctl_uop_valid,
  output logic                ib_ctl_uop_ready,
  output logic [RW-1:0]       result,
  output logic                vld_o,
  input  logic                result_ready
);

  localparam int ACCW = 2*DW + $clog2(LANES) + 4;
  localparam logic signed [ACCW-1:0] RW_MAX = {{(ACCW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] RW_MIN = {{(ACCW-RW+1){1'b1}}, {(RW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic                   relu_q, relu_d;
  logic [RW-1:0]          result_q, result_d;

  logic                   uop_fire;
  logic                   beat_fire;
  logic signed [ACCW-1:0] beat_sum;
  logic signed [ACCW-1:0] acc_sum;
  logic [1:0]             uop_unused;

  assign uop_unused = ib_ctl_uop[7:6];

  function automatic logic [RW-1:0] form_result(input logic signed [ACCW-1:0] a,
                                                input logic sat, input logic relu);
    logic [RW-1:0] r;
    if (sat && (a > RW_MAX))      r = RW_MAX[RW-1:0];
    else if (sat && (a < RW_MIN)) r = RW_MIN[RW-1:0];
    else                          r = a[RW-1:0];
    if (relu && r[RW-1]) r = '0;
    return r;
  endfunction

  // Each lane is sign-extended to ACCW before multiplying so no partial product truncates.
  always_comb begin
    logic signed [DW-1:0]   n_l, w_l;
    logic signed [ACCW-1:0] n_x, w_x;
    beat_sum = '0;
    n_l = '0; w_l = '0; n_x = '0; w_x = '0;
    for (int i = 0; i < LANES; i++) begin
      n_l = nram_mpe_neuron[i*DW +: DW];
      w_l = wram_mpe_weight[i*DW +: DW];
      n_x = n_l;
      w_x = w_l;
      beat_sum = beat_sum + n_x * w_x;
    end
  end

  assign ib_ctl_uop_ready      = (state_q == IDLE) || ((state_q == OUT) && result_ready);
  assign nram_mpe_neuron_ready = (state_q == ACC) && wram_mpe_weight_valid;
  assign wram_mpe_weight_ready = (state_q == ACC) && nram_mpe_neuron_valid;
  assign uop_fire  = ib_ctl_uop_valid && ib_ctl_uop_ready;
  assign beat_fire = (state_q == ACC) && nram_mpe_neuron_valid && wram_mpe_weight_valid;
  assign acc_sum   = acc_q + beat_sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    relu_d   = relu_q;
    result_d = result_q;
    if (uop_fire) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = ib_ctl_uop[3:0];
      sat_d   = ib_ctl_uop[4];
      relu_d  = ib_ctl_uop[5];
    end else begin
      unique case (state_q)
        ACC: begin
          if (beat_fire) begin
            acc_d = acc_sum;
            if (cnt_q == 4'd0) begin
              state_d  = OUT;
              result_d = form_result(acc_sum, sat_q, relu_q);
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        OUT:     if (result_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      relu_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      relu_q   <= relu_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign vld_o  = (state_q == OUT);

endmodule

// File: tb/tb_matrix_pe_param.sv
// Self-checking bench for matrix_pe_param: directed corner cases plus random
// uops checked against an arithmetic reference model.
module tb_matrix_pe_param;

  localparam int LANES = 32;
  localparam int DW    = 16;
  localparam int RW    = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [LANES*DW-1:0] nram_mpe_neuron;
  logic                nram_mpe_neuron_valid;
  logic                nram_mpe_neuron_ready;
  logic [LANES*DW-1:0] wram_mpe_weight;
  logic                wram_mpe_weight_valid;
  logic                wram_mpe_weight_ready;
  logic [7:0]          ib_ctl_uop;
  logic                ib_ctl_uop_valid;
  logic                ib_ctl_uop_ready;
  logic [RW-1:0]       result;
  logic                vld_o;
  logic                result_ready;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [LANES*DW-1:0] nb [16];
  logic [LANES*DW-1:0] wb [16];

  matrix_pe_param #(.LANES(LANES), .DW(DW), .RW(RW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .nram_mpe_neuron       (nram_mpe_neuron),
    .nram_mpe_neuron_valid (nram_mpe_neuron_valid),
    .nram_mpe_neuron_ready (nram_mpe_neuron_ready),
    .wram_mpe_weight       (wram_mpe_weight),
    .wram_mpe_weight_valid (wram_mpe_weight_valid),
    .wram_mpe_weight_ready (wram_mpe_weight_ready),
    .ib_ctl_uop            (ib_ctl_uop),
    .ib_ctl_uop_valid      (ib_ctl_uop_valid),
    .ib_ctl_uop_ready      (ib_ctl_uop_ready),
    .result                (result),
    .vld_o                 (vld_o),
    .result_ready          (result_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Dot product of every beat, summed as plain integers, then saturate/truncate and ReLU.
  function automatic logic [RW-1:0] model(input logic [7:0] u);
    longint      s = 0;
    shortint     a, c;
    logic [63:0] sv;
    logic [RW-1:0] r;
    for (int b = 0; b <= int'(u[3:0]); b++)
      for (int l = 0; l < LANES; l++) begin
        a = nb[b][l*DW +: DW];
        c = wb[b][l*DW +: DW];
        s += longint'(a) * longint'(c);
      end
    sv = s;
    if (u[4] && s > 64'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (u[4] && s < -64'sd2147483648) r = 32'h8000_0000;
    else                                   r = sv[RW-1:0];
    if (u[5] && r[RW-1]) r = '0;
    return r;
  endfunction

  task automatic fill(input int nbeats, input logic [DW-1:0] nv, input logic [DW-1:0] wv);
    for (int b = 0; b < nbeats; b++) begin
      nb[b] = {LANES{nv}};
      wb[b] = {LANES{wv}};
    end
  endtask

  task automatic fill_random(input int nbeats);
    for (int b = 0; b < nbeats; b++)
      for (int l = 0; l < LANES; l++) begin
        nb[b][l*DW +: DW] = ($urandom_range(0, 3) == 0) ? 16'h7FFF : DW'($urandom);
        wb[b][l*DW +: DW] = ($urandom_range(0, 3) == 0) ? 16'h8000 : DW'($urandom);
      end
  endtask

  task automatic issue_uop(input logic [7:0] u);
    int n = 0;
    ib_ctl_uop       = u;
    ib_ctl_uop_valid = 1'b1;
    #1;
    while (!ib_ctl_uop_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("uop_accept", ib_ctl_uop_ready, 1'b1);
    @(negedge clk);
    ib_ctl_uop_valid = 1'b0;
  endtask

  // mode 0: both valids every cycle; 1: random gaps; 2: neuron dropped 2 cycles before beat 2.
  task automatic feed_beats(input int nbeats, input int mode);
    int b = 0, cyc = 0, drop = 0, r;
    logic nv, wv;
    while (b < nbeats && cyc < 400) begin
      nram_mpe_neuron = nb[b];
      wram_mpe_weight = wb[b];
      nv = 1'b1; wv = 1'b1;
      if (mode == 1) begin
        r  = $urandom_range(0, 4);
        nv = (r != 1);
        wv = (r != 2);
      end else if (mode == 2 && b == 2 && drop < 2) begin
        nv = 1'b0;
        drop++;
      end
      nram_mpe_neuron_valid = nv;
      wram_mpe_weight_valid = wv;
      #1;
      check("n_ready", nram_mpe_neuron_ready, wv);
      check("w_ready", wram_mpe_weight_ready, nv);
      check("vld_in_acc", vld_o, 1'b0);
      if (nv && wv) b++;
      @(negedge clk);
      cyc++;
    end
    nram_mpe_neuron_valid = 1'b0;
    wram_mpe_weight_valid = 1'b0;
    check("beats_done", b, nbeats);
  endtask

  task automatic run_op(input logic [7:0] u, input int mode, input string tag,
                        output logic [RW-1:0] exp);
    exp = model(u);
    issue_uop(u);
    feed_beats(int'(u[3:0]) + 1, mode);
    #1;
    check({tag, "_vld"}, vld_o, 1'b1);
    check(tag, result, exp);
  endtask

  task automatic hold_out(input int cycles, input logic [RW-1:0] exp);
    result_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk); #1;
      check("hold_vld", vld_o, 1'b1);
      check("hold_result", result, exp);
      check("hold_uop_rdy", ib_ctl_uop_ready, 1'b0);
    end
  endtask

  task automatic release_out();
    result_ready = 1'b1;
    #1;
    check("out_uop_rdy", ib_ctl_uop_ready, 1'b1);
    @(negedge clk);
    result_ready = 1'b0;
    #1;
    check("vld_dropped", vld_o, 1'b0);
    check("idle_uop_rdy", ib_ctl_uop_ready, 1'b1);
  endtask

  initial begin
    logic [RW-1:0] exp;
    logic [7:0]    u;

    rst_n = 1'b0;
    nram_mpe_neuron = '0; wram_mpe_weight = '0;
    nram_mpe_neuron_valid = 1'b1; wram_mpe_weight_valid = 1'b1;
    ib_ctl_uop = '0; ib_ctl_uop_valid = 1'b0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_vld", vld_o, 1'b0);
    check("rst_result", result, 0);
    check("rst_uop_rdy", ib_ctl_uop_ready, 1'b1);
    check("rst_n_rdy", nram_mpe_neuron_ready, 1'b0);
    check("rst_w_rdy", wram_mpe_weight_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_ignores_data", nram_mpe_neuron_ready | wram_mpe_weight_ready, 1'b0);
    nram_mpe_neuron_valid = 1'b0; wram_mpe_weight_valid = 1'b0;

    // 1s x 2s, 4 beats, then backpressure for 3 cycles and a same-cycle handover.
    fill(4, 16'h0001, 16'h0002);
    run_op(8'h03, 0, "dot256", exp);
    check("dot256_const", result, 32'd256);
    hold_out(3, exp);
    fill(1, 16'h7FFF, 16'h7FFF);
    result_ready = 1'b1;
    issue_uop(8'h10);
    result_ready = 1'b0;
    #1;
    check("handover_vld", vld_o, 1'b0);
    feed_beats(1, 0);
    #1;
    check("sat_pos", result, 32'h7FFF_FFFF);
    check("sat_pos_model", result, model(8'h10));
    release_out();

    run_op(8'h00, 0, "wrap", exp);
    check("wrap_const", result, 32'hFFE0_0020);
    release_out();

    fill(1, 16'h0001, 16'hFFFF);
    run_op(8'h00, 0, "neg", exp);
    check("neg_const", result, 32'hFFFF_FFE0);
    release_out();
    run_op(8'h20, 0, "relu", exp);
    check("relu_const", result, 32'h0);
    release_out();

    fill(4, 16'h0001, 16'h0002);
    run_op(8'h03, 2, "gap", exp);
    check("gap_const", result, 32'd256);
    release_out();

    // Abort mid-accumulation: nothing from the aborted uop may surface.
    issue_uop(8'h03);
    feed_beats(2, 0);
    rst_n = 1'b0;
    nram_mpe_neuron_valid = 1'b1; wram_mpe_weight_valid = 1'b1;
    @(negedge clk); #1;
    check("abort_vld", vld_o, 1'b0);
    check("abort_result", result, 0);
    check("abort_uop_rdy", ib_ctl_uop_ready, 1'b1);
    check("abort_data_rdy", nram_mpe_neuron_ready | wram_mpe_weight_ready, 1'b0);
    rst_n = 1'b1;
    nram_mpe_neuron_valid = 1'b0; wram_mpe_weight_valid = 1'b0;
    @(negedge clk); #1;
    check("abort_idle_vld", vld_o, 1'b0);
    run_op(8'h00, 0, "post_rst", exp);
    check("post_rst_const", result, 32'd64);
    release_out();

    for (int t = 0; t < 14; t++) begin
      u = 8'($urandom);
      fill_random(int'(u[3:0]) + 1);
      run_op(u, 1, "rand", exp);
      hold_out($urandom_range(0, 3), exp);
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
